// File: rtl/automata_ctrl_pkg.sv
// Shared types for the automaton stream sequencer: controller states and the
// host-side view of a tagged report entry.
package automata_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RUN,
    DRAIN,
    DONE
  } ctrl_state_e;

  localparam int RPT_OFF_W   = 32;
  localparam int RPT_VEC_W   = 1;
  localparam int RPT_ENTRY_W = RPT_OFF_W + RPT_VEC_W;

  // Field order matches the packing used when entries are pushed into the FIFO.
  typedef struct packed {
    logic [RPT_OFF_W-1:0] offset;
    logic [RPT_VEC_W-1:0] vector;
  } rpt_entry_t;

endpackage

// File: rtl/automata_stream_ctrl_report_fifo.sv
// Synchronous report FIFO with an occupancy count so the sequencer can reserve
// room for reports still travelling through the tag pipe.
module report_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/automata_stream_ctrl.sv
// Job sequencer for one STE automaton: flush, stream stream_len symbols, tag
// each report with the offset of the symbol that completed it, queue for host.
module automata_stream_ctrl import automata_ctrl_pkg::*; #(
  parameter int SYM_W      = 8,
  parameter int NUM_RPT    = 1,
  parameter int OFF_W      = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int RPT_LAT    = 1,
  parameter int FLUSH_CYC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OFF_W-1:0]   stream_len,
  output logic               busy,
  output logic               done,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SYM_W-1:0]   s_symbol,
  output logic               ste_run,
  output logic               ste_reset,
  output logic [SYM_W-1:0]   ste_symbols,
  input  logic [NUM_RPT-1:0] ste_report,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [OFF_W-1:0]   r_offset,
  output logic [NUM_RPT-1:0] r_vector,
  output logic               overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = OFF_W + NUM_RPT;
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(FIFO_DEPTH - RPT_LAT);

  ctrl_state_e        state;
  ctrl_state_e        state_nxt;
  logic [OFF_W-1:0]   len_q;
  logic [OFF_W-1:0]   off_cnt;
  logic [FL_W-1:0]    flush_cnt;
  logic [RPT_LAT-1:0] vld_p;
  logic [OFF_W-1:0]   off_p [RPT_LAT];
  logic               beat;
  logic               last_beat;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENT_W-1:0]   pop_entry;

  // Keeping free > RPT_LAT guarantees every in-flight report has a slot.
  assign s_ready     = (state == RUN) && (fifo_count < READY_LIMIT);
  assign beat        = s_valid && s_ready;
  assign last_beat   = beat && (off_cnt == len_q - OFF_W'(1));
  assign ste_run     = beat;
  assign ste_symbols = s_symbol;
  assign ste_reset   = reset || (state == FLUSH);

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FLUSH;
      FLUSH: if (flush_cnt == FL_W'(FLUSH_CYC - 1))
               state_nxt = (len_q == '0) ? DRAIN : RUN;
      RUN:   if (last_beat) state_nxt = DRAIN;
      DRAIN: if (vld_p == '0) state_nxt = DONE;
      DONE:  begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= '0;
      off_cnt   <= '0;
      flush_cnt <= '0;
      overflow  <= 1'b0;
      vld_p     <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;
      if (state == IDLE && start) begin
        len_q    <= stream_len;
        off_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        if (beat) off_cnt <= off_cnt + OFF_W'(1);
        if (push && fifo_full && !pop) overflow <= 1'b1;
      end
      vld_p[0] <= beat;
      for (int i = 1; i < RPT_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Tag pipe: beat offset -> matching report RPT_LAT cycles later
  always_ff @(posedge clk) begin
    off_p[0] <= off_cnt;
    for (int i = 1; i < RPT_LAT; i++) off_p[i] <= off_p[i-1];
  end

  // Pipe tail: only a valid tail may push, so stalled STE outputs are never re-queued
  assign push = vld_p[RPT_LAT-1] && (|ste_report);
  assign pop  = r_valid && r_ready;

  report_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({off_p[RPT_LAT-1], ste_report}),
    .pop       (pop),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign r_valid               = !fifo_empty;
  assign {r_offset, r_vector}  = pop_entry;

  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_automata_stream_ctrl.sv
// Randomized bench: a case-insensitive "SRC" automaton drives ste_report, and
// expected report offsets are derived from each job's symbol list.
module tb_automata_stream_ctrl;

  localparam int SYM_W      = 8;
  localparam int NUM_RPT    = 1;
  localparam int OFF_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int RPT_LAT    = 1;
  localparam int FLUSH_CYC  = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [OFF_W-1:0]   stream_len = '0;
  logic               busy, done;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [SYM_W-1:0]   s_symbol = '0;
  logic               ste_run, ste_reset;
  logic [SYM_W-1:0]   ste_symbols;
  logic [NUM_RPT-1:0] ste_report;
  logic               r_valid;
  logic               r_ready = 1'b0;
  logic [OFF_W-1:0]   r_offset;
  logic [NUM_RPT-1:0] r_vector;
  logic               overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sym[$];
  int exp_off[$];

  automata_stream_ctrl #(
    .SYM_W(SYM_W), .NUM_RPT(NUM_RPT), .OFF_W(OFF_W),
    .FIFO_DEPTH(FIFO_DEPTH), .RPT_LAT(RPT_LAT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stream_len(stream_len),
    .busy(busy), .done(done), .s_valid(s_valid), .s_ready(s_ready),
    .s_symbol(s_symbol), .ste_run(ste_run), .ste_reset(ste_reset),
    .ste_symbols(ste_symbols), .ste_report(ste_report), .r_valid(r_valid),
    .r_ready(r_ready), .r_offset(r_offset), .r_vector(r_vector),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lc(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Automaton stand-in: registered report, held while run is low
  logic [7:0] h1, h2;
  logic       rpt;
  always @(posedge clk or posedge ste_reset) begin
    if (ste_reset) begin
      h1 <= 8'h00; h2 <= 8'h00; rpt <= 1'b0;
    end else if (ste_run) begin
      rpt <= (lc(h2) == 8'h73) && (lc(h1) == 8'h72) && (lc(ste_symbols) == 8'h63);
      h2  <= h1;
      h1  <= ste_symbols;
    end
  end
  assign ste_report = rpt;

  always @(negedge clk) begin
    if (!reset && r_valid && r_ready) begin
      check("entry_off", r_offset, exp_off.size() > 0 ? 64'(exp_off.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF);
      check("entry_vec", r_vector, 1);
    end
  end

  task automatic load(input string s, input int reps);
    sym.delete();
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < s.len(); i++) sym.push_back(s[i]);
  endtask

  task automatic run_job(input int len, input int vprob, input int rprob, input int hold, input int abort);
    int idx, cyc, beats, rst_cyc, done_cnt, bad_run;
    bit fin, b;
    idx = 0; cyc = 0; beats = 0; rst_cyc = 0; done_cnt = 0; bad_run = 0; fin = 0;
    for (int i = 2; i < len; i++)
      if (lc(sym[i-2]) == 8'h73 && lc(sym[i-1]) == 8'h72 && lc(sym[i]) == 8'h63)
        exp_off.push_back(i);
    @(posedge clk); #1;
    start = 1'b1; stream_len = OFF_W'(len); s_valid = 1'b0; r_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      b = s_valid && s_ready;
      if (ste_reset) rst_cyc++;
      if (ste_run !== b || (b && ste_symbols !== s_symbol)) bad_run++;
      if (b) beats++;
      if (done) done_cnt++;
      if (hold > 0 && cyc == hold) begin
        check("hold_s_ready", s_ready, 0);
        check("hold_r_valid", r_valid, 1);
      end
      if (abort > 0 && cyc == abort) begin
        check("pre_reset_r_valid", r_valid, 1);
        reset = 1'b1;
        #1;
        check("rst_r_valid", r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_ste_reset", ste_reset, 1);
        exp_off.delete();
        @(posedge clk); #1;
        reset = 1'b0; s_valid = 1'b0; r_ready = 1'b0;
        return;
      end
      if (done_cnt > 0 && !busy) fin = 1;
      @(posedge clk); #1;
      if (b) idx++;
      start      = (cyc == 0);
      stream_len = OFF_W'(len + 5);
      s_valid    = (idx < len) && ($urandom_range(99) < vprob);
      s_symbol   = (idx < len) ? sym[idx] : 8'h00;
      r_ready    = (cyc >= hold) && ($urandom_range(99) < rprob);
      cyc++;
    end
    start = 1'b0;
    check("job_finished", fin, 1);
    check("flush_cycles", rst_cyc, FLUSH_CYC);
    check("run_beats", beats, len);
    check("done_pulses", done_cnt, 1);
    check("run_follows_beat", bad_run, 0);
    s_valid = 1'b0; r_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!r_valid && exp_off.size() == 0) break;
    end
    check("entries_left", exp_off.size(), 0);
    check("r_valid_drained", r_valid, 0);
    check("overflow", overflow, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    string alpha;
    int len;
    alpha = "SRCsrcx";
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_s_ready0", s_ready, 0);
    check("rst_ste_run0", ste_run, 0);
    check("rst_r_valid0", r_valid, 0);
    check("rst_overflow0", overflow, 0);
    check("rst_ste_reset0", ste_reset, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    load("SRC", 1);      run_job(3, 100, 100, 0, 0);
    load("xsRcSRC", 1);  run_job(7, 100, 100, 0, 0);
    load("SRC", 8);      run_job(24, 100, 100, 60, 0);
    sym.delete();        run_job(0, 100, 100, 0, 0);
    load("SRC", 4);      run_job(12, 100, 0, 0, 9);
    load("SRC", 1);      run_job(3, 100, 100, 0, 0);

    for (int j = 0; j < 10; j++) begin
      len = $urandom_range(30);
      sym.delete();
      for (int i = 0; i < len; i++) sym.push_back(alpha[$urandom_range(6)]);
      run_job(len, 30 + $urandom_range(70), 20 + $urandom_range(80), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
